and_gate: RTL and testbench
===========================

Name: and_gate

Overview:
- Registered two-input AND of board switch inputs, driving one LED output.
- Sits at the board I/O boundary.
- Each switch input passes through a synchronizer and an optional debounce filter. The filtered levels are ANDed and registered onto the LED.
- Purpose: a clean, glitch-free logical AND of two asynchronous mechanical switches in the i_clk domain.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer chain (legal range 1..4).
- DEBOUNCE_CYCLES, 250000, number of consecutive i_clk cycles a synchronized input must hold a new level before it is accepted. Used only when AND_GATE_DEBOUNCE_EN is defined; legal range >= 1.

Ports:
- i_clk  input  1  system clock; all state is updated on its rising edge.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_switch_1  input  1  switch 1 level; asynchronous to i_clk.
- i_switch_2  input  1  switch 2 level; asynchronous to i_clk.
- o_led_1  output  1  registered AND of the filtered switch levels.

Behaviour:
- One clock domain (i_clk). Reset is synchronous and active-low on i_rst_n.
- While i_rst_n = 0 at a rising edge:
  - all synchronizer flops, debounce counters and stable-level registers clear to 0;
  - o_led_1 = 0 from that edge onward.
- Reset asserted mid-operation takes effect at the next rising edge regardless of switch state. Outputs stay 0 for as long as i_rst_n is low.
- Synchronizer:
  - Each switch feeds its own SYNC_STAGES-deep flop chain.
  - The chain's last flop is the synchronized level s_n.
- Debounce stage, when enabled: see Optional Feature.
- Debounce stage, when disabled: filtered level f_n = s_n.
- Output register: o_led_1 <= f_1 & f_2 on every rising edge when not in reset.
- Latency from a switch level change to o_led_1 change, without debounce: SYNC_STAGES + 1 cycles (3 cycles at default).
- The output never glitches; it changes only at rising edges.
- Input changes between edges are sampled at the next edge. Pulses shorter than one clock period may be missed; this is allowed.
- Both switches changing on the same edge propagate together. o_led_1 reflects the new AND after the stated latency.
- Width rule: all datapath signals are 1 bit. Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).
- No unknown (X) values on o_led_1 after the first reset edge.

Optional Feature:
- Macro: AND_GATE_DEBOUNCE_EN.
- Defined — per channel, a counter cnt_n and a stable register f_n operate as follows on each edge:
  - if s_n == f_n: cnt_n <= 0;
  - else if cnt_n == DEBOUNCE_CYCLES-1: f_n <= s_n and cnt_n <= 0;
  - else cnt_n <= cnt_n + 1.
- Effect when defined:
  - A new level must persist DEBOUNCE_CYCLES consecutive cycles to be accepted; shorter bounces are rejected and restart the count.
  - Latency = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Not defined:
  - no counters are instantiated;
  - f_n = s_n;
  - latency = SYNC_STAGES + 1 cycles.

Test Plan:
- Reset: hold i_rst_n = 0 for 3 cycles with both switches = 1 -> o_led_1 = 0 throughout. Release reset -> o_led_1 = 1 exactly 3 cycles later (no debounce, SYNC_STAGES = 2).
- Truth table without debounce: apply switch pairs 00, 01, 10, 11, each held 10 cycles -> o_led_1 reads 0, 0, 0, 1, each value appearing 3 cycles after the input change.
- Simultaneous change: switches go 11 -> 00 on the same cycle -> o_led_1 falls exactly 3 cycles later, with no intermediate 1 glitch or extra transition.
- Debounce with AND_GATE_DEBOUNCE_EN defined, DEBOUNCE_CYCLES = 4:
  - switch_2 held at 1;
  - switch_1 pulsed high for 3 cycles -> o_led_1 stays 0;
  - switch_1 then held high -> o_led_1 = 1 at cycle 2 + 4 + 1 = 7 after the rise.
- Bounce rejection with debounce enabled:
  - switch_1 toggles 1, 0, 1, 0 each cycle, then settles at 1 -> count restarts at each toggle;
  - o_led_1 rises 7 cycles after the final settle.
- Reset mid-operation: o_led_1 = 1, assert i_rst_n = 0 between edges -> o_led_1 = 0 after the next rising edge. Deassert with switches 11 -> output returns to 1 after the full latency.

Source files
------------

// File: rtl/and_gate.sv
// Registered AND of two asynchronous switches: per-channel synchronizer, optional
// debounce filter (enabled by defining AND_GATE_DEBOUNCE_EN), then output flop.
module and_gate #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_switch_1,
  input  logic i_switch_2,
  output logic o_led_1
);

  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("and_gate: SYNC_STAGES must be in 1..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("and_gate: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [1:0]                  sw;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0]                  sync_lvl;
  logic [1:0]                  filt;
  logic                        led_q, led_d;

  assign sw = {i_switch_2, i_switch_1};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        sync_q[ch][0] <= sw[ch];
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
          sync_q[ch][k] <= sync_q[ch][k-1];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < 2; ch++) begin
      sync_lvl[ch] = sync_q[ch][SYNC_STAGES-1];
    end
  end

`ifdef AND_GATE_DEBOUNCE_EN
  localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            filt_q, filt_d;

  // Any cycle where the synchronized level matches the accepted level restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int unsigned ch = 0; ch < 2; ch++) begin
      if (sync_lvl[ch] != filt_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          filt_d[ch] = sync_lvl[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      filt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_lvl;
`endif

  assign led_d = filt[0] & filt[1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
    end
  end

  assign o_led_1 = led_q;

endmodule

// File: tb/tb_and_gate.sv
// Directed self-checking bench for and_gate; debounce scenarios run when
// AND_GATE_DEBOUNCE_EN is defined (DEBOUNCE_CYCLES overridden to 4).
module tb_and_gate;

`ifdef AND_GATE_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw1 = 1'b0;
  logic sw2 = 1'b0;
  logic led;

  int n_pass  = 0;
  int n_total = 0;

`ifdef AND_GATE_DEBOUNCE_EN
  and_gate #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
`else
  and_gate #(.SYNC_STAGES(2)) dut (
`endif
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_switch_1 (sw1),
    .i_switch_2 (sw2),
    .o_led_1    (led)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw1 = 1'b1; sw2 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      n_total++;
      if (led !== 1'b0) $display("FAIL reset_hold cycle %0d: o_led_1=%b expected 0", c, led);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      logic exp;
      cyc();
      exp = (c >= LAT);
      n_total++;
      if (led !== exp) $display("FAIL reset_release cycle %0d: o_led_1=%b expected %b", c, led, exp);
      else n_pass++;
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] pairs [4];
    logic       outs  [4];
    logic       prev;
    pairs = '{2'b00, 2'b01, 2'b10, 2'b11};
    outs  = '{1'b0, 1'b0, 1'b0, 1'b1};
    prev  = 1'b1;
    for (int p = 0; p < 4; p++) begin
      logic [1:0] pr;
      pr = pairs[p];
      sw1 = pr[1]; sw2 = pr[0];
      for (int c = 1; c <= 10; c++) begin
        logic exp;
        cyc();
        exp = (c >= LAT) ? outs[p] : prev;
        n_total++;
        if (led !== exp)
          $display("FAIL truth_%b cycle %0d: o_led_1=%b expected %b", pr, c, led, exp);
        else n_pass++;
      end
      prev = outs[p];
    end
  endtask

  task automatic test_simultaneous();
    sw1 = 1'b0; sw2 = 1'b0;
    for (int c = 1; c <= LAT + 4; c++) begin
      logic exp;
      cyc();
      exp = (c < LAT);
      n_total++;
      if (led !== exp) $display("FAIL simultaneous_fall cycle %0d: o_led_1=%b expected %b", c, led, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    sw1 = 1'b1; sw2 = 1'b1;
    repeat (LAT + 3) cyc();
    n_total++;
    if (led !== 1'b1) $display("FAIL midreset_pre: o_led_1=%b expected 1", led);
    else n_pass++;
    rst_n = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      cyc();
      n_total++;
      if (led !== 1'b0) $display("FAIL midreset_hold cycle %0d: o_led_1=%b expected 0", c, led);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      logic exp;
      cyc();
      exp = (c >= LAT);
      n_total++;
      if (led !== exp) $display("FAIL midreset_release cycle %0d: o_led_1=%b expected %b", c, led, exp);
      else n_pass++;
    end
  endtask

`ifdef AND_GATE_DEBOUNCE_EN
  task automatic settle_sw1_low();
    sw1 = 1'b0; sw2 = 1'b1;
    repeat (12) cyc();
    n_total++;
    if (led !== 1'b0) $display("FAIL debounce_settle: o_led_1=%b expected 0", led);
    else n_pass++;
  endtask

  task automatic test_debounce();
    settle_sw1_low();
    sw1 = 1'b1;
    repeat (3) cyc();
    sw1 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      n_total++;
      if (led !== 1'b0) $display("FAIL debounce_short_pulse cycle %0d: o_led_1=%b expected 0", c, led);
      else n_pass++;
    end
    sw1 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      logic exp;
      cyc();
      exp = (c >= 7);
      n_total++;
      if (led !== exp) $display("FAIL debounce_hold cycle %0d: o_led_1=%b expected %b", c, led, exp);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pattern;
    settle_sw1_low();
    pattern = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      sw1 = pattern[i];
      cyc();
    end
    sw1 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      logic exp;
      cyc();
      exp = (c >= 7);
      n_total++;
      if (led !== exp) $display("FAIL bounce_settle cycle %0d: o_led_1=%b expected %b", c, led, exp);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_truth_table();
    test_simultaneous();
    test_reset_mid_op();
`ifdef AND_GATE_DEBOUNCE_EN
    test_debounce();
    test_bounce();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
